// File: rtl/sprite_desc_writer_pkg.sv
// Shared constants for the sprite descriptor path: screen size defaults,
// select/field codes and the bit layout of a 64-bit descriptor.
package sprite_desc_writer_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int FIELD_W     = 16;
    localparam int DESC_W      = 64;
    localparam int NUM_SPRITES = 3;

    localparam logic [1:0] SEL_P1    = 2'd0;
    localparam logic [1:0] SEL_P2    = 2'd1;
    localparam logic [1:0] SEL_STAGE = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;

    localparam logic [1:0] FLD_X = 2'd0;
    localparam logic [1:0] FLD_Y = 2'd1;
    localparam logic [1:0] FLD_W = 2'd2;
    localparam logic [1:0] FLD_H = 2'd3;

    // Descriptor layout, also consumed by isInsideSprite
    localparam int X_LSB = 0;
    localparam int Y_LSB = 16;
    localparam int W_LSB = 32;
    localparam int H_LSB = 48;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    function automatic logic [5:0] fld_lsb(input logic [1:0] fld);
        return {fld, 4'b0000};
    endfunction

endpackage

// File: rtl/desc_clamp.sv
// Combinational clamp of one descriptor so the sprite never extends past
// the visible area; x and y are passed through untouched.
module desc_clamp
    import sprite_desc_writer_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic [DESC_W-1:0] i_desc,
    output logic [DESC_W-1:0] o_desc
);

    localparam logic [16:0] H_LIM = 17'(H_ACTIVE);
    localparam logic [16:0] V_LIM = 17'(V_ACTIVE);

    // 17-bit sum so a huge length cannot wrap past the limit test
    function automatic logic [15:0] clamp_len(input logic [15:0] pos,
                                              input logic [15:0] len,
                                              input logic [16:0] lim);
        logic [16:0] sum;
        sum = {1'b0, pos} + {1'b0, len};
        if ({1'b0, pos} >= lim)
            return 16'd0;
        else if (sum > lim)
            return 16'(lim - {1'b0, pos});
        else
            return len;
    endfunction

    logic [15:0] w_x, w_y, w_w, w_h;

    assign w_x = i_desc[X_LSB +: FIELD_W];
    assign w_y = i_desc[Y_LSB +: FIELD_W];
    assign w_w = i_desc[W_LSB +: FIELD_W];
    assign w_h = i_desc[H_LSB +: FIELD_W];

    assign o_desc = {clamp_len(w_y, w_h, V_LIM), clamp_len(w_x, w_w, H_LIM), w_y, w_x};

endmodule

// File: rtl/sprite_desc_writer.sv
// Double-buffered sprite descriptors: software fills a shadow bank at any
// time and a commit swaps the clamped shadow into the live set at vsync.
module sprite_desc_writer
    import sprite_desc_writer_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iVS,
    input  logic              iWE,
    input  logic [1:0]        iSEL,
    input  logic [1:0]        iFIELD,
    input  logic [15:0]       iDATA,
    input  logic              iCOMMIT,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [15:0]       oFRAME,
    output logic [DESC_W-1:0] p1VGA,
    output logic [DESC_W-1:0] p2VGA,
    output logic [DESC_W-1:0] stageVGA
);

    state_t r_state, w_state_nxt;
    logic   r_vs_prev;
    logic   r_done;
    logic [15:0] r_frame;
    logic [NUM_SPRITES-1:0][DESC_W-1:0] r_shadow;
    logic [NUM_SPRITES-1:0][DESC_W-1:0] r_live;
    logic [NUM_SPRITES-1:0][DESC_W-1:0] w_clamped;
    logic   w_boundary;
    logic   w_commit;

    assign w_boundary = r_vs_prev & ~iVS;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_clamp
        desc_clamp #(
            .H_ACTIVE (H_ACTIVE),
            .V_ACTIVE (V_ACTIVE)
        ) u_clamp (
            .i_desc (r_shadow[g]),
            .o_desc (w_clamped[g])
        );
    end

    // A commit requested in IDLE never fires in its own cycle, even on a boundary
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE:  if (iCOMMIT) w_state_nxt = ST_ARMED;
            ST_ARMED: if (w_boundary) begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_state   <= ST_IDLE;
            r_vs_prev <= 1'b1;
            r_done    <= 1'b0;
            r_frame   <= '0;
            r_shadow  <= '0;
            r_live    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_vs_prev <= iVS;
            r_done    <= w_commit;
            if (w_boundary)
                r_frame <= r_frame + 16'd1;
            // Live samples the pre-write shadow when a write lands on the commit edge
            if (w_commit)
                r_live <= w_clamped;
            for (int s = 0; s < NUM_SPRITES; s++)
                if (iWE && iSEL == 2'(s))
                    r_shadow[s][fld_lsb(iFIELD) +: FIELD_W] <= iDATA;
        end
    end

    assign oBUSY    = (r_state == ST_ARMED);
    assign oDONE    = r_done;
    assign oFRAME   = r_frame;
    assign p1VGA    = r_live[SEL_P1];
    assign p2VGA    = r_live[SEL_P2];
    assign stageVGA = r_live[SEL_STAGE];

endmodule

// File: tb/tb_sprite_desc_writer.sv
// Directed bench for sprite_desc_writer: a clamp vector table plus
// hand-written sequences for commit timing, reset and frame-counter wrap.
module tb_sprite_desc_writer;

    logic        iVGA_CLK = 1'b0;
    logic        iRST_n   = 1'b0;
    logic        iVS      = 1'b1;
    logic        iWE      = 1'b0;
    logic [1:0]  iSEL     = 2'd0;
    logic [1:0]  iFIELD   = 2'd0;
    logic [15:0] iDATA    = 16'd0;
    logic        iCOMMIT  = 1'b0;
    logic        oBUSY, oDONE;
    logic [15:0] oFRAME;
    logic [63:0] p1VGA, p2VGA, stageVGA;

    int total = 0;
    int bad   = 0;
    int dbl_done = 0;
    logic done_q = 1'b0;

    sprite_desc_writer dut (
        .iVGA_CLK (iVGA_CLK), .iRST_n (iRST_n), .iVS (iVS), .iWE (iWE),
        .iSEL (iSEL), .iFIELD (iFIELD), .iDATA (iDATA), .iCOMMIT (iCOMMIT),
        .oBUSY (oBUSY), .oDONE (oDONE), .oFRAME (oFRAME),
        .p1VGA (p1VGA), .p2VGA (p2VGA), .stageVGA (stageVGA)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    always @(negedge iVGA_CLK) begin
        if (done_q && oDONE) dbl_done++;
        done_q <= oDONE;
    end

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] x, y, w, h;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge iVGA_CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] live(input logic [1:0] sel);
        case (sel)
            2'd0:    return p1VGA;
            2'd1:    return p2VGA;
            default: return stageVGA;
        endcase
    endfunction

    task automatic wr(input logic [1:0] sel, input logic [1:0] fld, input logic [15:0] d);
        iWE = 1'b1; iSEL = sel; iFIELD = fld; iDATA = d;
        step();
        iWE = 1'b0;
    endtask

    task automatic commit();
        iCOMMIT = 1'b1;
        step();
        iCOMMIT = 1'b0;
    endtask

    // iVS high for one edge, then low for one edge (the boundary edge)
    task automatic boundary();
        iVS = 1'b1;
        step();
        iVS = 1'b0;
        step();
        iVS = 1'b1;
    endtask

    initial begin
        vecs[0] = '{2'd0, 16'd100, 16'd50,  16'd32,     16'd48,     64'h0030_0020_0032_0064};
        vecs[1] = '{2'd2, 16'd620, 16'd0,   16'd40,     16'd10,     64'h000A_0014_0000_026C};
        vecs[2] = '{2'd2, 16'd700, 16'd0,   16'd40,     16'd10,     64'h000A_0000_0000_02BC};
        vecs[3] = '{2'd1, 16'd0,   16'd470, 16'd640,    16'd20,     64'h000A_0280_01D6_0000};
        vecs[4] = '{2'd1, 16'd639, 16'd479, 16'hFFFF,   16'hFFFF,   64'h0001_0001_01DF_027F};
        vecs[5] = '{2'd0, 16'hFFFF,16'd480, 16'd5,      16'd5,      64'h0000_0000_01E0_FFFF};

        step(); step();
        iRST_n = 1'b1;
        chk("rst_busy",  64'(oBUSY),  64'd0);
        chk("rst_done",  64'(oDONE),  64'd0);
        chk("rst_frame", 64'(oFRAME), 64'd0);
        chk("rst_p1",    p1VGA,    64'd0);
        chk("rst_p2",    p2VGA,    64'd0);
        chk("rst_stage", stageVGA, 64'd0);

        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].sel, 2'd0, vecs[i].x);
            wr(vecs[i].sel, 2'd1, vecs[i].y);
            wr(vecs[i].sel, 2'd2, vecs[i].w);
            wr(vecs[i].sel, 2'd3, vecs[i].h);
            chk($sformatf("v%0d_prelive", i), 64'(live(vecs[i].sel) == vecs[i].exp), 64'(i == 1 && 1'b0));
            commit();
            chk($sformatf("v%0d_busy", i), 64'(oBUSY), 64'd1);
            boundary();
            chk($sformatf("v%0d_live", i), live(vecs[i].sel), vecs[i].exp);
            chk($sformatf("v%0d_done", i), 64'(oDONE), 64'd1);
            chk($sformatf("v%0d_busy_clr", i), 64'(oBUSY), 64'd0);
            step();
            chk($sformatf("v%0d_done_clr", i), 64'(oDONE), 64'd0);
        end
        chk("frame_after_table", 64'(oFRAME), 64'd6);

        // Shadow write on the commit edge: live keeps old x, shadow keeps new x
        commit();
        iVS = 1'b1;
        step();
        iVS = 1'b0; iWE = 1'b1; iSEL = 2'd1; iFIELD = 2'd0; iDATA = 16'd5;
        step();
        iWE = 1'b0; iVS = 1'b1;
        chk("wr_commit_live", p2VGA, 64'h0001_0001_01DF_027F);
        chk("wr_commit_done", 64'(oDONE), 64'd1);
        step();
        commit();
        boundary();
        chk("wr_commit_next", p2VGA, 64'h0001_027B_01DF_0005);

        // Commit in the same cycle as a boundary from IDLE waits a frame
        wr(2'd0, 2'd0, 16'd1);
        begin
            logic [15:0] f0;
            f0 = oFRAME;
            iVS = 1'b1;
            step();
            iVS = 1'b0; iCOMMIT = 1'b1;
            step();
            iCOMMIT = 1'b0; iVS = 1'b1;
            chk("same_cyc_busy", 64'(oBUSY), 64'd1);
            chk("same_cyc_done", 64'(oDONE), 64'd0);
            chk("same_cyc_p1",   p1VGA, 64'h0000_0000_01E0_FFFF);
            boundary();
            chk("same_cyc_p1_next", p1VGA, 64'h0000_0005_01E0_0001);
            chk("same_cyc_done2",   64'(oDONE), 64'd1);
            chk("same_cyc_frame",   64'(oFRAME), 64'(f0 + 16'd2));
            step();
        end

        // Reset while armed drops the pending commit
        commit();
        chk("arm_before_rst", 64'(oBUSY), 64'd1);
        iRST_n = 1'b0;
        step();
        iRST_n = 1'b1;
        chk("rst2_busy",  64'(oBUSY),  64'd0);
        chk("rst2_frame", 64'(oFRAME), 64'd0);
        boundary();
        chk("rst2_p1",    p1VGA,    64'd0);
        chk("rst2_p2",    p2VGA,    64'd0);
        chk("rst2_stage", stageVGA, 64'd0);
        chk("rst2_done",  64'(oDONE), 64'd0);
        chk("rst2_frame1", 64'(oFRAME), 64'd1);

        // Frame counter wrap: 65535 more boundaries brings it to 0
        for (int n = 0; n < 65535; n++) begin
            iVS = 1'b1;
            step();
            iVS = 1'b0;
            step();
        end
        iVS = 1'b1;
        chk("frame_wrap", 64'(oFRAME), 64'd0);

        // iSEL=3 writes touch nothing
        for (int f = 0; f < 4; f++) wr(2'd3, 2'(f), 16'h1234);
        commit();
        boundary();
        chk("sel3_p1",    p1VGA,    64'd0);
        chk("sel3_p2",    p2VGA,    64'd0);
        chk("sel3_stage", stageVGA, 64'd0);
        chk("sel3_done",  64'(oDONE), 64'd1);
        step(); step();

        chk("done_never_double", 64'(dbl_done), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
